// File: rtl/cpu_ctrl_pkg.sv
// Package: cpu_ctrl_pkg
// Shared types and encodings for the CPU control FSM and its IR decoder.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W   = 16;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned NSEL_W = 3;

  // Major opcode field ir[15:13]
  localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
  localparam logic [OPC_W-1:0] OPC_LDR  = 3'b011;
  localparam logic [OPC_W-1:0] OPC_STR  = 3'b100;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  // Sub-op field ir[12:11]
  localparam logic [OP_W-1:0] OP_MOVI = 2'b10;
  localparam logic [OP_W-1:0] OP_MOVR = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP  = 2'b01;
  localparam logic [OP_W-1:0] OP_AND  = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN  = 2'b11;
  localparam logic [OP_W-1:0] OP_MEM  = 2'b00;
  localparam logic [OP_W-1:0] OP_HALT = 2'b00;

  // One-hot regfile select {Rm,Rd,Rn}
  localparam logic [NSEL_W-1:0] NSEL_RN = 3'b001;
  localparam logic [NSEL_W-1:0] NSEL_RD = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM = 3'b100;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    VSEL_C      = 2'b00,
    VSEL_PC     = 2'b01,
    VSEL_SXIMM8 = 2'b10,
    VSEL_MDATA  = 2'b11
  } vsel_e;

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPC, S_DEC, S_GETA, S_GETB, S_EXEC, S_WBC,
    S_WBI, S_ADDR, S_LDA, S_MRD, S_WBM, S_STB, S_MWR, S_HLT
  } state_e;

  typedef enum logic [3:0] {
    CL_MOVI, CL_MOVR, CL_ADD, CL_CMP, CL_AND, CL_MVN,
    CL_LDR, CL_STR, CL_HALT, CL_ILL
  } instr_cls_e;

  // Full set of datapath strobes driven by the FSM
  typedef struct packed {
    logic              reset_pc;
    logic              load_pc;
    logic              addr_sel;
    logic              load_addr;
    mem_cmd_e          mem_cmd;
    logic              load_ir;
    logic [NSEL_W-1:0] nsel;
    vsel_e             vsel;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              halted;
    logic              illegal;
  } ctrl_out_t;

endpackage

// File: rtl/cpu_ir_decode.sv
// Module: cpu_ir_decode
// Combinational instruction classifier: {opc,op} -> class plus illegal flag.
module cpu_ir_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  input  logic [OP_W-1:0]  op,
  output instr_cls_e       cls,
  output logic             illegal
);

  // Map each legal opcode pair to its class; everything else is illegal
  always_comb begin
    cls = CL_ILL;
    case ({opc, op})
      {OPC_MOV,  OP_MOVI}: cls = CL_MOVI;
      {OPC_MOV,  OP_MOVR}: cls = CL_MOVR;
      {OPC_ALU,  OP_ADD }: cls = CL_ADD;
      {OPC_ALU,  OP_CMP }: cls = CL_CMP;
      {OPC_ALU,  OP_AND }: cls = CL_AND;
      {OPC_ALU,  OP_MVN }: cls = CL_MVN;
      {OPC_LDR,  OP_MEM }: cls = CL_LDR;
      {OPC_STR,  OP_MEM }: cls = CL_STR;
      {OPC_HALT, OP_HALT}: cls = CL_HALT;
      default:             cls = CL_ILL;
    endcase
    illegal = (cls == CL_ILL);
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Module: cpu_ctrl_fsm
// Control FSM for the 16-bit RISC datapath: fetch/decode/execute/writeback
// sequencing with registered Moore strobes. Optional `define RETIRE_CNT_EN
// adds a 16-bit retired-instruction counter output.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned RD_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] start_pc,
  input  logic [IR_W-1:0] ir,
  output logic            reset_pc,
  output logic            load_pc,
  output logic            addr_sel,
  output logic            load_addr,
  output logic [1:0]      mem_cmd,
  output logic            load_ir,
  output logic [2:0]      nsel,
  output logic [1:0]      vsel,
  output logic            write,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
`ifdef RETIRE_CNT_EN
  output logic [15:0]     retired,
`endif
  output logic            halted,
  output logic            illegal
);

  localparam int unsigned CNT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

  state_e     state_q, state_d;
  ctrl_out_t  out_d, out_q;
  instr_cls_e cls;
  logic       dec_illegal;
  logic       ill_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic       wait_done;

  // start_pc feeds the datapath PC mux directly; the FSM only times that load
  logic unused_inputs;
  assign unused_inputs = ^{ir[IR_W-OPC_W-OP_W-1:0], start_pc};

  cpu_ir_decode u_decode (
    .opc     (ir[IR_W-1 -: OPC_W]),
    .op      (ir[IR_W-OPC_W-1 -: OP_W]),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign wait_done = (wait_cnt_q == CNT_W'(RD_WAIT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Next-state and per-state strobe decode
  always_comb begin
    state_d = state_q;
    out_d   = '0;
    unique case (state_q)
      S_RESET: begin
        out_d.reset_pc = 1'b1;
        out_d.load_pc  = 1'b1;
        state_d        = S_IF1;
      end
      S_IF1: begin
        out_d.addr_sel = 1'b1;
        out_d.mem_cmd  = MEM_READ;
        if (wait_done) state_d = S_IF2;
      end
      S_IF2: begin
        out_d.addr_sel = 1'b1;
        out_d.mem_cmd  = MEM_READ;
        out_d.load_ir  = 1'b1;
        state_d        = S_UPC;
      end
      S_UPC: begin
        out_d.load_pc = 1'b1;
        state_d       = S_DEC;
      end
      S_DEC: begin
        case (cls)
          CL_MOVI:                                 state_d = S_WBI;
          CL_MOVR, CL_MVN:                         state_d = S_GETB;
          CL_ADD, CL_AND, CL_CMP, CL_LDR, CL_STR:  state_d = S_GETA;
          default:                                 state_d = S_HLT;
        endcase
      end
      S_GETA: begin
        out_d.nsel  = NSEL_RN;
        out_d.loada = 1'b1;
        state_d     = (cls == CL_LDR || cls == CL_STR) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        out_d.nsel  = NSEL_RM;
        out_d.loadb = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (cls == CL_CMP) out_d.loads = 1'b1;
        else               out_d.loadc = 1'b1;
        out_d.asel = (cls == CL_MOVR) || (cls == CL_MVN) || (cls == CL_STR);
        if (cls == CL_CMP)      state_d = S_IF1;
        else if (cls == CL_STR) state_d = S_MWR;
        else                    state_d = S_WBC;
      end
      S_WBC: begin
        out_d.nsel  = NSEL_RD;
        out_d.vsel  = VSEL_C;
        out_d.write = 1'b1;
        state_d     = S_IF1;
      end
      S_WBI: begin
        out_d.nsel  = NSEL_RN;
        out_d.vsel  = VSEL_SXIMM8;
        out_d.write = 1'b1;
        state_d     = S_IF1;
      end
      S_ADDR: begin
        out_d.bsel  = 1'b1;
        out_d.loadc = 1'b1;
        state_d     = S_LDA;
      end
      S_LDA: begin
        out_d.load_addr = 1'b1;
        state_d         = (cls == CL_LDR) ? S_MRD : S_STB;
      end
      S_MRD: begin
        out_d.mem_cmd = MEM_READ;
        if (wait_done) state_d = S_WBM;
      end
      S_WBM: begin
        out_d.mem_cmd = MEM_READ;
        out_d.nsel    = NSEL_RD;
        out_d.vsel    = VSEL_MDATA;
        out_d.write   = 1'b1;
        state_d       = S_IF1;
      end
      S_STB: begin
        out_d.nsel  = NSEL_RD;
        out_d.loadb = 1'b1;
        state_d     = S_EXEC;
      end
      S_MWR: begin
        out_d.mem_cmd = MEM_WRITE;
        state_d       = S_IF1;
      end
      S_HLT: begin
        out_d.halted  = 1'b1;
        out_d.illegal = ill_q;
      end
      default: state_d = S_RESET;
    endcase
  end

  // Read wait counter: holds IF1/MRD for RD_WAIT extra cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt_q <= '0;
    else if ((state_q == S_IF1 || state_q == S_MRD) && !wait_done)
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    else
      wait_cnt_q <= '0;
  end

  // Sticky record that the halt was caused by an undecodable instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ill_q <= 1'b0;
    else if (state_q == S_DEC && dec_illegal) ill_q <= 1'b1;
  end

  // Output register; async reset forces every strobe low immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign reset_pc  = out_q.reset_pc;
  assign load_pc   = out_q.load_pc;
  assign addr_sel  = out_q.addr_sel;
  assign load_addr = out_q.load_addr;
  assign mem_cmd   = out_q.mem_cmd;
  assign load_ir   = out_q.load_ir;
  assign nsel      = out_q.nsel;
  assign vsel      = out_q.vsel;
  assign write     = out_q.write;
  assign loada     = out_q.loada;
  assign loadb     = out_q.loadb;
  assign loadc     = out_q.loadc;
  assign loads     = out_q.loads;
  assign asel      = out_q.asel;
  assign bsel      = out_q.bsel;
  assign halted    = out_q.halted;
  assign illegal   = out_q.illegal;

`ifdef RETIRE_CNT_EN
  logic retire_c;

  // Last state of each completed non-HALT instruction
  assign retire_c = (state_q == S_WBI) || (state_q == S_WBC) ||
                    (state_q == S_WBM) || (state_q == S_MWR) ||
                    (state_q == S_EXEC && cls == CL_CMP);

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired <= '0;
    else if (retire_c) retired <= retired + 16'd1;
  end
`endif

endmodule
